// File: rtl/rs_issue_select.sv
// rs_issue_select: per-FU round-robin issue select with registered issue slots and accept/free pulses
module rs_issue_select #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_FUS = 4,
  parameter int BUSY_W = 4,
  localparam int IDXW = $clog2(NUM_ROWS),
  localparam int FUW = $clog2(NUM_FUS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_ROWS-1:0]          req_vec,
  input  logic [NUM_ROWS*FUW-1:0]      req_fu,
  input  logic [NUM_FUS*BUSY_W-1:0]    fu_occ,
  input  logic [NUM_FUS-1:0]           fu_ready,
  output logic [NUM_FUS-1:0]           issue_valid,
  output logic [NUM_FUS*IDXW-1:0]      issue_index,
  output logic [NUM_ROWS-1:0]          selected_mask,
  output logic                         clear_en,
  output logic [NUM_FUS*NUM_ROWS-1:0]  clear_lines,
  output logic [NUM_FUS-1:0]           free_valid,
  output logic [NUM_FUS*IDXW-1:0]      free_index
);
  logic [NUM_FUS-1:0] valid_q, valid_d, fv_q, fv_d, acc, sel_en, found;
  logic [NUM_FUS-1:0][IDXW-1:0] idx_q, idx_d, ptr_q, ptr_d, fi_q, fi_d, pick;
  logic [NUM_FUS-1:0][BUSY_W-1:0] busy_q, busy_d, occ;
  logic [NUM_FUS-1:0][NUM_ROWS-1:0] cand;
  logic [NUM_ROWS-1:0] mask_q, mask_d;
  logic [NUM_FUS*NUM_ROWS-1:0] clr_q, clr_d;
  logic clr_en_q;
  assign occ = fu_occ;
  assign acc = valid_q & fu_ready;
  always_comb begin
    cand = '0;
    found = '0;
    pick = '0;
    sel_en = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      sel_en[f] = busy_q[f] == '0 && (!valid_q[f] || (acc[f] && occ[f] == '0));
      for (int j = 0; j < NUM_ROWS; j++)
        cand[f][j] = req_vec[j] && req_fu[j*FUW +: FUW] == FUW'(f) && !mask_q[j];
      for (int o = NUM_ROWS - 1; o >= 0; o--)
        if (cand[f][IDXW'(ptr_q[f] + IDXW'(o))]) begin
          found[f] = 1'b1;
          pick[f] = IDXW'(ptr_q[f] + IDXW'(o));
        end
    end
  end
  always_comb begin
    valid_d = valid_q;
    idx_d = idx_q;
    mask_d = mask_q;
    ptr_d = ptr_q;
    fi_d = fi_q;
    clr_d = '0;
    fv_d = '0;
    busy_d = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      busy_d[f] = busy_q[f] != '0 ? busy_q[f] - BUSY_W'(1) : '0;
      if (acc[f]) begin
        valid_d[f] = 1'b0;
        busy_d[f] = occ[f];
        clr_d[f*NUM_ROWS + int'(idx_q[f])] = 1'b1;
        fv_d[f] = 1'b1;
        fi_d[f] = idx_q[f];
        mask_d[idx_q[f]] = 1'b0;
      end
    end
    for (int f = 0; f < NUM_FUS; f++)
      if (sel_en[f] && found[f]) begin
        valid_d[f] = 1'b1;
        idx_d[f] = pick[f];
        mask_d[pick[f]] = 1'b1;
        ptr_d[f] = IDXW'(pick[f] + IDXW'(1));
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      idx_q <= '0;
      mask_q <= '0;
      busy_q <= '0;
      ptr_q <= '0;
      clr_q <= '0;
      fv_q <= '0;
      fi_q <= '0;
      clr_en_q <= 1'b0;
    end else if (flush) begin
      valid_q <= '0;
      mask_q <= '0;
      busy_q <= '0;
      ptr_q <= '0;
      clr_q <= '0;
      fv_q <= '0;
      clr_en_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      idx_q <= idx_d;
      mask_q <= mask_d;
      busy_q <= busy_d;
      ptr_q <= ptr_d;
      clr_q <= clr_d;
      fv_q <= fv_d;
      fi_q <= fi_d;
      clr_en_q <= |clr_d;
    end
  end
  assign issue_valid = valid_q;
  assign issue_index = idx_q;
  assign selected_mask = mask_q;
  assign clear_en = clr_en_q;
  assign clear_lines = clr_q;
  assign free_valid = fv_q;
  assign free_index = fi_q;
endmodule
